// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// div_unit : multi-cycle restoring divider for MIPS DIV/DIVU (LO=quo, HI=rem)
// Rev 1.0
// ============================================================================
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic [WIDTH-1:0] quo_q, rem_q, dvs_q, dvd_raw_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_quo_q, neg_rem_q, zero_q, ovf_q;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_d, quo_d;

  always_comb begin
    neg_a   = is_signed & dividend[WIDTH-1];
    neg_b   = is_signed & divisor[WIDTH-1];
    dvd_mag = neg_a ? (~dividend + 1'b1) : dividend;
    dvs_mag = neg_b ? (~divisor + 1'b1) : divisor;
    // One extra bit: the shifted remainder can reach 2*divisor-1.
    trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    rem_d   = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      dvd_raw_q <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            dbz_q     <= 1'b0;
            quo_q     <= dvd_mag;
            rem_q     <= '0;
            dvs_q     <= dvs_mag;
            dvd_raw_q <= dividend;
            cnt_q     <= '0;
            neg_quo_q <= neg_a ^ neg_b;
            neg_rem_q <= neg_a;
            zero_q    <= (divisor == '0);
            ovf_q     <= is_signed && (dividend == MIN_NEG) && (divisor == '1);
          end
        end
        S_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= S_FIX;
        end
        S_FIX: begin
          if (zero_q) begin
            lo_q  <= '1;
            hi_q  <= dvd_raw_q;
            dbz_q <= 1'b1;
          end else if (ovf_q) begin
            lo_q <= MIN_NEG;
            hi_q <= '0;
          end else begin
            lo_q <= neg_quo_q ? (~quo_q + 1'b1) : quo_q;
            hi_q <= neg_rem_q ? (~rem_q + 1'b1) : rem_q;
          end
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign lo          = lo_q;
  assign hi          = hi_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative integer divider. It is the inverse companion to the single-cycle combinational multiply in the datapath ALU.
- Executes MIPS DIV/DIVU and writes quotient to LO and remainder to HI.
- Sits beside the ALU in EX. The control unit stalls the pipeline while busy is high.
- Uses a one-bit-per-cycle restoring algorithm with a start/busy/done handshake.

Parameters:
WIDTH, 32, operand/result width in bits. Latency scales as WIDTH+2.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
is_signed  input  1  1 = DIV (two's complement), 0 = DIVU
dividend  input  WIDTH  operand A (rs)
divisor  input  WIDTH  operand B (rt)
busy  output  1  high from cycle after accepted start until done cycle, inclusive
done  output  1  single-cycle pulse; hi/lo valid from this cycle
lo  output  WIDTH  quotient register
hi  output  WIDTH  remainder register
div_by_zero  output  1  registered flag for last op, valid with done, held until next accepted start

Behaviour:
Reset:
- Synchronous, active-high, on any edge with rst=1, regardless of state.
- On reset: state=IDLE; busy=0; done=0; lo=0; hi=0; div_by_zero=0.
- An in-flight op is abandoned, with no done pulse and no partial result.

States and transitions:
- IDLE:
  - On start=1, latch operands and is_signed.
  - Record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend); both forced to 0 when unsigned.
  - Load |dividend| and |divisor|; magnitudes use unsigned WIDTH-bit negation.
  - Clear partial remainder and counter; go to RUN.
  - start=0: stay in IDLE.
- RUN (WIDTH cycles):
  - Each cycle, shift {rem, quo} left 1.
  - Trial-subtract divisor magnitude from rem using a WIDTH+1-bit subtract.
  - If non-negative, keep the difference and set quo[0]=1; else restore and set quo[0]=0.
  - Counter runs 0..WIDTH-1; after the last iteration go to FIX.
- FIX (1 cycle): apply the sign and special-case fixes below, write lo/hi, go to DONE.
- DONE (1 cycle): done=1, busy=1; go to IDLE.

Latency and handshake:
- Start is accepted at edge k. busy=1 from cycle k+1 through cycle k+WIDTH+2. done=1 only in cycle k+WIDTH+2. busy=0 from cycle k+WIDTH+3.
- Latency is fixed at 34 cycles for WIDTH=32, including the special cases.
- start while busy is ignored: no queueing, operands not re-latched.
- start in the same cycle as done is ignored. The next start is accepted at the earliest in the cycle after done.
- hi/lo change only in FIX (and on reset). They hold their values indefinitely otherwise, including across ignored starts.

Sign and special-case rules (FIX):
- Normal case: lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem. The quotient truncates toward zero and the remainder takes the sign of the dividend.
- Divisor == 0: lo = all ones, hi = dividend as supplied, div_by_zero=1. This applies in both signed and unsigned mode.
- Signed overflow (dividend = 0x80000000, divisor = 0xFFFFFFFF): lo = 0x80000000, hi = 0, div_by_zero=0.
- Signed magnitude of 0x80000000 is 0x80000000, interpreted unsigned; the datapath is sized so no overflow occurs.

Test Plan:
1. Reset: hold rst 2 cycles -> lo=0, hi=0, busy=0, done=0. Start DIVU 100/7 -> done exactly 34 cycles after the start edge, lo=14, hi=2, single done pulse.
2. Signed: DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 7/-2 -> lo=-3, hi=1.
3. Unsigned large: DIVU 0xFFFFFFFF/0x00000010 -> lo=0x0FFFFFFF, hi=0xF. The same operands as DIV (-1/16) -> lo=0, hi=0xFFFFFFFF.
4. Specials: DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0. DIVU 55/0 -> lo=0xFFFFFFFF, hi=55, div_by_zero=1, latency still 34.
5. Handshake: start DIVU 9/3, then pulse start with 50/5 at cycle +10 and in the done cycle -> both ignored, lo=3, hi=0. Start 50/5 the cycle after done -> lo=10, hi=0.
6. Reset mid-op: start DIVU 1000/3, assert rst at cycle +15 -> next cycle state IDLE, busy=0, lo=hi=0, no done pulse. A new start then completes normally.
